pong_game_ctrl: RTL and testbench

PONG_GAME_CTRL -- requirements
Module: pong_game_ctrl

---
 rtl/pong_pkg.sv | 25 ++
 rtl/edge_detect.sv | 30 +++
 rtl/pong_game_ctrl.sv | 106 ++++++++++
 tb/tb_pong_game_ctrl.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/pong_pkg.sv
// pong_pkg: definitions shared by the pong game controller and the ball tracker.
//   state_t     - game controller FSM states
//   WINNER_*    - encodings for the 2-bit winner output
//   H_RES/V_RES - 640x480 display resolution
//   DELAY_W     - width of the serve delay counter (covers 50_000_000 cycles)
package pong_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SERVE,
    ST_PLAY,
    ST_POINT,
    ST_OVER
  } state_t;

  localparam logic [1:0] WINNER_NONE = 2'b00;
  localparam logic [1:0] WINNER_P1   = 2'b01;
  localparam logic [1:0] WINNER_P2   = 2'b10;

  localparam int unsigned H_RES = 640;
  localparam int unsigned V_RES = 480;

  localparam int unsigned DELAY_W = 26;

endpackage

// File: rtl/edge_detect.sv
// edge_detect: single-register rising-edge detector.
//   clk   - clock
//   reset - asynchronous active-low reset
//   in    - level input
//   rise  - high for the cycle where in is high and was low on the previous cycle
// A level already high when reset releases is not an edge: the detector only
// arms once it has seen the input low.
module edge_detect (
  input  logic clk,
  input  logic reset,
  input  logic in,
  output logic rise
);

  logic in_q;
  logic armed;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      in_q  <= 1'b0;
      armed <= 1'b0;
    end else begin
      in_q <= in;
      if (!in) armed <= 1'b1;
    end
  end

  assign rise = in & ~in_q & armed;

endmodule

// File: rtl/pong_game_ctrl.sv
// pong_game_ctrl: game sequencing for pong (serve, play, scoring, game over).
//   clk           - 50 MHz clock
//   reset         - asynchronous active-low reset
//   start         - debounced start button level
//   player1_point - ball tracker: player 1 scored (level)
//   player2_point - ball tracker: player 2 scored (level)
//   paddle_hit    - ball tracker: ball struck a paddle (level)
//   game_on       - high while the ball may move
//   ball_reset    - active-low one-cycle pulse on the first SERVE cycle
//   score1/score2 - player scores, 0..WIN_SCORE
//   winner        - 00 none, 01 player 1, 10 player 2
//   rally         - paddle hits in the current rally, saturating at 255
module pong_game_ctrl
  import pong_pkg::*;
#(
  parameter int unsigned WIN_SCORE   = 7,
  parameter int unsigned SERVE_DELAY = 50_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       player1_point,
  input  logic       player2_point,
  input  logic       paddle_hit,
  output logic       game_on,
  output logic       ball_reset,
  output logic [3:0] score1,
  output logic [3:0] score2,
  output logic [1:0] winner,
  output logic [7:0] rally
);

  localparam logic [3:0]         WIN  = 4'(WIN_SCORE);
  localparam logic [DELAY_W-1:0] LOAD = DELAY_W'(SERVE_DELAY - 1);

  state_t             state, state_n;
  logic [DELAY_W-1:0] cnt;
  logic               start_rise, p1_rise, p2_rise, hit_rise;
  logic               enter_serve;

  edge_detect u_start (.clk(clk), .reset(reset), .in(start),         .rise(start_rise));
  edge_detect u_p1    (.clk(clk), .reset(reset), .in(player1_point), .rise(p1_rise));
  edge_detect u_p2    (.clk(clk), .reset(reset), .in(player2_point), .rise(p2_rise));
  edge_detect u_hit   (.clk(clk), .reset(reset), .in(paddle_hit),    .rise(hit_rise));

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_n;
  end

  // Next-state logic
  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE:  if (start_rise) state_n = ST_SERVE;
      ST_SERVE: if (cnt == '0) state_n = ST_PLAY;
      ST_PLAY: begin
        if (p1_rise && p2_rise)      state_n = ST_SERVE;
        else if (p1_rise || p2_rise) state_n = ST_POINT;
      end
      ST_POINT: state_n = (score1 == WIN || score2 == WIN) ? ST_OVER : ST_SERVE;
      ST_OVER:  if (start_rise) state_n = ST_SERVE;
      default:  state_n = ST_IDLE;
    endcase
  end

  // Outputs; the counter holds LOAD only on the first SERVE cycle
  always_comb begin
    game_on    = (state == ST_PLAY);
    ball_reset = !((state == ST_SERVE) && (cnt == LOAD));
  end

  assign enter_serve = (state_n == ST_SERVE) && (state != ST_SERVE);

  // Datapath: delay counter, scores, winner, rally
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt    <= '0;
      score1 <= '0;
      score2 <= '0;
      winner <= WINNER_NONE;
      rally  <= '0;
    end else begin
      if (enter_serve)                       cnt <= LOAD;
      else if (state == ST_SERVE && cnt != '0) cnt <= cnt - 1'b1;

      if (start_rise && (state == ST_IDLE || state == ST_OVER)) begin
        score1 <= '0;
        score2 <= '0;
        winner <= WINNER_NONE;
      end else if (state == ST_PLAY) begin
        if (p1_rise && !p2_rise && score1 < WIN) score1 <= score1 + 1'b1;
        if (p2_rise && !p1_rise && score2 < WIN) score2 <= score2 + 1'b1;
      end else if (state == ST_POINT && state_n == ST_OVER) begin
        winner <= (score1 == WIN) ? WINNER_P1 : WINNER_P2;
      end

      if (enter_serve)
        rally <= '0;
      else if (state == ST_PLAY && hit_rise && rally != '1)
        rally <= rally + 1'b1;
    end
  end

endmodule

// File: tb/tb_pong_game_ctrl.sv
module tb_pong_game_ctrl;

  localparam int unsigned WS = 3;
  localparam int unsigned SD = 4;

  logic       clk = 1'b0;
  logic       reset, start, player1_point, player2_point, paddle_hit;
  logic       game_on, ball_reset;
  logic [3:0] score1, score2;
  logic [1:0] winner;
  logic [7:0] rally;

  pong_game_ctrl #(.WIN_SCORE(WS), .SERVE_DELAY(SD)) dut (
    .clk(clk), .reset(reset), .start(start),
    .player1_point(player1_point), .player2_point(player2_point),
    .paddle_hit(paddle_hit), .game_on(game_on), .ball_reset(ball_reset),
    .score1(score1), .score2(score2), .winner(winner), .rally(rally)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      tag;
    logic       on;
    logic       br;
    logic [3:0] s1;
    logic [3:0] s2;
    logic [1:0] win;
    logic [7:0] ral;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad   = 0;

  // Reference model of the outputs
  logic       m_on, m_br;
  logic [3:0] m_s1, m_s2;
  logic [1:0] m_win;
  logic [7:0] m_rally;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cmp(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(string tag);
    exp_t e;
    e.tag = tag; e.on = m_on; e.br = m_br; e.s1 = m_s1;
    e.s2 = m_s2; e.win = m_win; e.ral = m_rally;
    sb.push_back(e);
  endtask

  task automatic pop_cmp();
    exp_t e;
    e = sb.pop_front();
    cmp({e.tag, ".game_on"},    32'(game_on),    32'(e.on));
    cmp({e.tag, ".ball_reset"}, 32'(ball_reset), 32'(e.br));
    cmp({e.tag, ".score1"},     32'(score1),     32'(e.s1));
    cmp({e.tag, ".score2"},     32'(score2),     32'(e.s2));
    cmp({e.tag, ".winner"},     32'(winner),     32'(e.win));
    cmp({e.tag, ".rally"},      32'(rally),      32'(e.ral));
  endtask

  task automatic check(string tag);
    push_exp(tag);
    pop_cmp();
  endtask

  // Called on the first SERVE cycle; walks the serve and ends on the first PLAY cycle.
  task automatic serve_seq(string tag);
    m_on = 1'b0; m_br = 1'b0; m_rally = '0;
    check({tag, ".serve_first"});
    m_br = 1'b1;
    for (int unsigned i = 1; i < SD; i++) begin
      tick();
      check({tag, ".serve_hold"});
    end
    tick();
    m_on = 1'b1;
    check({tag, ".play"});
  endtask

  // One-cycle pulse on a point input during PLAY; ends on the POINT cycle.
  task automatic point(input int unsigned who);
    if (who == 1) player1_point = 1'b1; else player2_point = 1'b1;
    tick();
    player1_point = 1'b0; player2_point = 1'b0;
    if (who == 1) m_s1 = m_s1 + 1'b1; else m_s2 = m_s2 + 1'b1;
    m_on = 1'b0; m_br = 1'b1;
    check("point");
    tick();
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; player1_point = 1'b0;
    player2_point = 1'b0; paddle_hit = 1'b0;
    m_on = 1'b0; m_br = 1'b1; m_s1 = '0; m_s2 = '0; m_win = 2'b00; m_rally = '0;
    tick(); tick();
    check("reset");
    reset = 1'b1;
    tick(); tick();
    check("idle");

    // Start -> serve -> play
    start = 1'b1; tick(); start = 1'b0;
    serve_seq("start");

    // Player 1 wins 3-0
    for (int unsigned n = 0; n < WS - 1; n++) begin
      point(1);
      serve_seq("reserve");
    end
    point(1);
    m_win = 2'b01;
    check("over_p1");
    player2_point = 1'b1; tick(); player2_point = 1'b0; tick();
    check("over_ignore_point");

    // Restart from OVER
    start = 1'b1; tick(); start = 1'b0;
    m_s1 = '0; m_s2 = '0; m_win = 2'b00;
    serve_seq("restart");

    // Rally counting and saturation
    for (int unsigned i = 0; i < 3; i++) begin
      paddle_hit = 1'b1; tick(); paddle_hit = 1'b0; tick();
      m_rally = m_rally + 1'b1;
    end
    check("rally3");
    for (int unsigned i = 3; i < 300; i++) begin
      paddle_hit = 1'b1; tick(); paddle_hit = 1'b0; tick();
      if (m_rally != 8'd255) m_rally = m_rally + 1'b1;
    end
    check("rally_sat");
    start = 1'b1; tick(); start = 1'b0; tick();
    check("play_ignore_start");
    point(2);
    serve_seq("rally_cleared");

    // Simultaneous points -> re-serve without scoring
    player1_point = 1'b1; player2_point = 1'b1; tick();
    player1_point = 1'b0; player2_point = 1'b0;
    serve_seq("tie");

    // Player 2 wins
    point(2);
    serve_seq("p2_second");
    point(2);
    m_win = 2'b10;
    check("over_p2");

    // Restart with score2=3, point pulses in SERVE ignored
    start = 1'b1; tick(); start = 1'b0;
    m_s1 = '0; m_s2 = '0; m_win = 2'b00; m_on = 1'b0; m_br = 1'b0; m_rally = '0;
    check("restart2");
    m_br = 1'b1;
    player1_point = 1'b1; tick(); player1_point = 1'b0;
    player2_point = 1'b1; tick(); player2_point = 1'b0;
    check("serve_ignore_points");
    tick();
    check("serve_last");
    tick();
    m_on = 1'b1;
    check("play_after_ignore");

    // Reset during second SERVE cycle
    point(1);
    m_br = 1'b0; m_rally = '0;
    check("pre_reset_serve");
    tick();
    start = 1'b1;
    reset = 1'b0;
    #1;
    m_on = 1'b0; m_br = 1'b1; m_s1 = '0; m_s2 = '0; m_win = 2'b00; m_rally = '0;
    check("async_reset");
    tick();
    reset = 1'b1;
    for (int unsigned i = 0; i < 2 * SD; i++) tick();
    check("start_held_idle");
    start = 1'b0; tick();
    start = 1'b1; tick(); start = 1'b0;
    serve_seq("start_after_release");

    if (sb.size() != 0) begin
      total++; bad++;
      $error("FAIL scoreboard_leftover observed=%0d expected=0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
